namuru_time_base: RTL

NAMURU_TIME_BASE -- requirements
Module: namuru_time_base

---
 rtl/namuru_pkg.sv | 14 +
 rtl/namuru_divcnt.sv | 64 ++++++
 rtl/namuru_time_base.sv | 64 ++++++
 3 files changed

// File: rtl/namuru_pkg.sv
// Shared defaults and types for the Namuru time base.
// The divide counters are sized and reset from these constants.
package namuru_pkg;
   localparam int          NAMURU_DIV_W       = 24;
   localparam logic [23:0] NAMURU_TIC_DIV_RST = 24'd16367;
   localparam logic [23:0] NAMURU_ACC_DIV_RST = 24'd16;

   typedef enum logic [1:0] {
      DC_RESET,
      DC_LOAD,
      DC_HOLD,
      DC_RUN
   } divcnt_mode_e;
endpackage

// File: rtl/namuru_divcnt.sv
// Down counter with a shadow divide value and a registered terminal-count pulse.
// The period is shadow + 1 clocks; a load or hold always suppresses the pulse.
module namuru_divcnt
   import namuru_pkg::*;
#(
   parameter int               DIV_W   = NAMURU_DIV_W,
   parameter logic [DIV_W-1:0] RST_VAL = DIV_W'(NAMURU_TIC_DIV_RST)
) (
   input  logic             clks,
   input  logic             rstn,
   input  logic             load_i,
   input  logic             enable_i,
   input  logic [DIV_W-1:0] div_i,
   output logic [DIV_W-1:0] count_o,
   output logic             pulse_o
);

   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] count_q, count_d;
   logic             pulse_q, pulse_d;
   divcnt_mode_e     mode;

   always_ff @(posedge clks) begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
   end

   always_comb begin
      mode     = DC_RUN;
      shadow_d = shadow_q;
      count_d  = count_q;
      pulse_d  = 1'b0;

      if (!rstn)          mode = DC_RESET;
      else if (load_i)    mode = DC_LOAD;
      else if (!enable_i) mode = DC_HOLD;

      case (mode)
         DC_RESET: begin
            shadow_d = RST_VAL;
            count_d  = RST_VAL;
         end
         DC_LOAD: begin
            shadow_d = div_i;
            count_d  = div_i;
         end
         DC_HOLD: count_d = shadow_q;
         default: begin
            // Reload at zero instead of decrementing, so the count never wraps.
            if (count_q == '0) begin
               count_d = shadow_q;
               pulse_d = 1'b1;
            end else begin
               count_d = count_q - DIV_W'(1);
            end
         end
      endcase
   end

   assign count_o = count_q;
   assign pulse_o = pulse_q;

endmodule

// File: rtl/namuru_time_base.sv
// Tic and accumulation time base for the Namuru correlator, clocked by clks.
// Divide values are loaded by a pre-synchronized toggle handshake and echoed back as load_ack.
module namuru_time_base
   import namuru_pkg::*;
#(
   parameter int               DIV_W       = NAMURU_DIV_W,
   parameter logic [DIV_W-1:0] TIC_DIV_RST = DIV_W'(NAMURU_TIC_DIV_RST),
   parameter logic [DIV_W-1:0] ACC_DIV_RST = DIV_W'(NAMURU_ACC_DIV_RST)
) (
   input  logic             clks,
   input  logic             rstn,
   input  logic             enable_s,
   input  logic             load_tgl_s,
   input  logic [DIV_W-1:0] tic_divide,
   input  logic [DIV_W-1:0] accum_divide,
   output logic             load_ack,
   output logic             tic_enable,
   output logic             accum_enable,
   output logic [DIV_W-1:0] tic_count
);

   logic load_tgl_d;
   logic load_evt;
   logic [DIV_W-1:0] accum_count;

   // Tracking the toggle also in reset keeps release from looking like a load.
   always_ff @(posedge clks) begin
      load_tgl_d <= load_tgl_s;
   end

   assign load_evt = load_tgl_s ^ load_tgl_d;
   assign load_ack = load_tgl_d;

   namuru_divcnt #(
      .DIV_W   (DIV_W),
      .RST_VAL (TIC_DIV_RST)
   ) u_tic (
      .clks     (clks),
      .rstn     (rstn),
      .load_i   (load_evt),
      .enable_i (enable_s),
      .div_i    (tic_divide),
      .count_o  (tic_count),
      .pulse_o  (tic_enable)
   );

   namuru_divcnt #(
      .DIV_W   (DIV_W),
      .RST_VAL (ACC_DIV_RST)
   ) u_accum (
      .clks     (clks),
      .rstn     (rstn),
      .load_i   (load_evt),
      .enable_i (enable_s),
      .div_i    (accum_divide),
      .count_o  (accum_count),
      .pulse_o  (accum_enable)
   );

   // The accumulation count is internal only; no snapshot of it is exported.
   logic unused_ok;
   assign unused_ok = ^accum_count;

endmodule
